// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM: sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK,
// bounds memory-ready waits with a timeout trap and counts retired instructions.
module multicycle_control_unit #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic             Zero,
  input  logic             Lt,
  input  logic             Ltu,
  input  logic             mem_ready,
  output logic             MemReq,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic [1:0]       PCSrc,
  output logic             MemWrite,
  output logic [2:0]       MemSrc,
  output logic [3:0]       ALUControl,
  output logic             ALUSrc,
  output logic [2:0]       ImmSrc,
  output logic             RegWrite,
  output logic [1:0]       RegWSrc,
  output logic [2:0]       state,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] instret
);

  // state | meaning: FETCH instr read, DECODE classify, EXECUTE ALU/branch,
  // MEMORY data access, WRITEBACK reg+PC update, TRAP halted until rst
  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_TRAP      = 3'd7
  } state_t;

  localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_PASS = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_OR   = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;

  state_t             r_state;
  logic [WAIT_W-1:0]  r_wait;
  logic               r_trap;
  logic [1:0]         r_cause;
  logic [CNT_W-1:0]   r_instret;

  logic w_is_r, w_is_i, w_is_load, w_is_store, w_is_br;
  logic w_is_jal, w_is_jalr, w_is_lui, w_legal, w_taken;
  logic [3:0] w_alu_ctrl;

  assign w_is_r     = (op == OP_R);
  assign w_is_i     = (op == OP_I);
  assign w_is_load  = (op == OP_LOAD);
  assign w_is_store = (op == OP_STORE);
  assign w_is_br    = (op == OP_BR);
  assign w_is_jal   = (op == OP_JAL);
  assign w_is_jalr  = (op == OP_JALR);
  assign w_is_lui   = (op == OP_LUI);
  assign w_legal    = w_is_r | w_is_i | w_is_load | w_is_store |
                      w_is_br | w_is_jal | w_is_jalr | w_is_lui;

  always_comb begin
    case (funct3)
      3'b000:  w_taken = Zero;
      3'b001:  w_taken = !Zero;
      3'b100:  w_taken = Lt;
      3'b101:  w_taken = !Lt;
      3'b110:  w_taken = Ltu;
      3'b111:  w_taken = !Ltu;
      default: w_taken = 1'b0;
    endcase
  end

  // Only R-type funct7=0100000 selects sub; immediates never do.
  always_comb begin
    w_alu_ctrl = ALU_ADD;
    if (w_is_br) begin
      w_alu_ctrl = ALU_SUB;
    end else if (w_is_lui) begin
      w_alu_ctrl = ALU_PASS;
    end else if (w_is_r || w_is_i) begin
      case (funct3)
        3'b000:  w_alu_ctrl = (w_is_r && funct7 == 7'b0100000) ? ALU_SUB : ALU_ADD;
        3'b001:  w_alu_ctrl = ALU_SLL;
        3'b010:  w_alu_ctrl = ALU_SLT;
        3'b011:  w_alu_ctrl = ALU_SLTU;
        3'b100:  w_alu_ctrl = ALU_XOR;
        3'b101:  w_alu_ctrl = funct7[5] ? ALU_SRA : ALU_SRL;
        3'b110:  w_alu_ctrl = ALU_OR;
        default: w_alu_ctrl = ALU_AND;
      endcase
    end
  end

  always_comb begin
    MemReq     = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    PCSrc      = 2'd0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    RegWSrc    = 2'd0;
    MemSrc     = funct3;
    ALUControl = w_alu_ctrl;
    ALUSrc     = !(w_is_r || w_is_br);
    if (w_is_br)         ImmSrc = 3'd1;
    else if (w_is_store) ImmSrc = 3'd2;
    else if (w_is_jal)   ImmSrc = 3'd3;
    else if (w_is_lui)   ImmSrc = 3'd4;
    else                 ImmSrc = 3'd0;
    // Strobes are suppressed while rst is held so a reset aborts cleanly.
    if (!rst) begin
      case (r_state)
        S_FETCH: begin
          MemReq  = 1'b1;
          IRWrite = mem_ready;
        end
        S_EXECUTE: begin
          if (w_is_br) begin
            PCWrite = 1'b1;
            PCSrc   = w_taken ? 2'd1 : 2'd0;
          end
        end
        S_MEMORY: begin
          MemReq   = 1'b1;
          MemWrite = w_is_store;
          PCWrite  = w_is_store && mem_ready;
        end
        S_WRITEBACK: begin
          RegWrite = 1'b1;
          PCWrite  = 1'b1;
          if (w_is_load)                  RegWSrc = 2'd1;
          else if (w_is_jal || w_is_jalr) RegWSrc = 2'd2;
          if (w_is_jal)       PCSrc = 2'd1;
          else if (w_is_jalr) PCSrc = 2'd2;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_wait    <= '0;
      r_trap    <= 1'b0;
      r_cause   <= 2'd0;
      r_instret <= '0;
    end else begin
      if (PCWrite) r_instret <= r_instret + CNT_W'(1);
      case (r_state)
        S_FETCH, S_MEMORY: begin
          if (mem_ready) begin
            r_wait <= '0;
            if (r_state == S_FETCH)  r_state <= S_DECODE;
            else if (w_is_store)     r_state <= S_FETCH;
            else                     r_state <= S_WRITEBACK;
          end else if (r_wait == WAIT_LAST) begin
            r_wait  <= '0;
            r_state <= S_TRAP;
            r_trap  <= 1'b1;
            r_cause <= 2'd2;
          end else begin
            r_wait <= r_wait + WAIT_W'(1);
          end
        end
        S_DECODE: begin
          if (w_legal) begin
            r_state <= S_EXECUTE;
          end else begin
            r_state <= S_TRAP;
            r_trap  <= 1'b1;
            r_cause <= 2'd1;
          end
        end
        S_EXECUTE: begin
          r_wait <= '0;
          if (w_is_br)                      r_state <= S_FETCH;
          else if (w_is_load || w_is_store) r_state <= S_MEMORY;
          else                              r_state <= S_WRITEBACK;
        end
        S_WRITEBACK: begin
          r_wait  <= '0;
          r_state <= S_FETCH;
        end
        S_TRAP:  r_state <= S_TRAP;
        default: r_state <= S_FETCH;
      endcase
    end
  end

  assign state      = r_state;
  assign trap       = r_trap;
  assign trap_cause = r_cause;
  assign instret    = r_instret;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: random RV32I instruction streams against a
// per-instruction cycle model, plus directed trap, timeout, wrap and reset cases.
module tb_multicycle_control_unit;

  localparam int TO = 4;
  localparam int CW = 3;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [6:0] op = '0;
  logic [2:0] funct3 = '0;
  logic [6:0] funct7 = '0;
  logic Zero = 1'b0, Lt = 1'b0, Ltu = 1'b0, mem_ready = 1'b0;
  logic MemReq, IRWrite, PCWrite, MemWrite, ALUSrc, RegWrite, trap;
  logic [1:0] PCSrc, RegWSrc, trap_cause;
  logic [2:0] MemSrc, ImmSrc, state;
  logic [3:0] ALUControl;
  logic [CW-1:0] instret;

  multicycle_control_unit #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7(funct7),
    .Zero(Zero), .Lt(Lt), .Ltu(Ltu), .mem_ready(mem_ready),
    .MemReq(MemReq), .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc),
    .MemWrite(MemWrite), .MemSrc(MemSrc), .ALUControl(ALUControl),
    .ALUSrc(ALUSrc), .ImmSrc(ImmSrc), .RegWrite(RegWrite), .RegWSrc(RegWSrc),
    .state(state), .trap(trap), .trap_cause(trap_cause), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic       rdy, memreq, irw, pcw, memw, regw;
    logic [1:0] pcsrc, wsrc;
  } exp_t;

  int n_tests = 0;
  int n_fail  = 0;
  logic [CW-1:0] exp_instret = '0;
  exp_t q[$];

  logic [6:0]  cur_op;
  logic [2:0]  cur_f3;
  logic [6:0]  cur_f7;
  logic        cur_zero, cur_lt, cur_ltu;
  logic [3:0]  exp_alu;
  logic [2:0]  exp_imm;
  logic        exp_alusrc;

  logic [6:0]  legal_ops [8] = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BR, OP_JAL, OP_JALR, OP_LUI};
  logic [2:0]  br_f3 [6]     = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
  logic [31:0] vals [5]      = '{32'd0, 32'd1, 32'd2, 32'hFFFF_FFFF, 32'h8000_0000};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  function automatic exp_t mk(input logic [2:0] st, input logic rdy, mr, irw, pcw, mw, rw,
                              input logic [1:0] ps, ws);
    exp_t e;
    e.st = st; e.rdy = rdy; e.memreq = mr; e.irw = irw; e.pcw = pcw;
    e.memw = mw; e.regw = rw; e.pcsrc = ps; e.wsrc = ws;
    return e;
  endfunction

  function automatic logic is_legal(input logic [6:0] o);
    for (int i = 0; i < 8; i++) if (legal_ops[i] == o) return 1'b1;
    return 1'b0;
  endfunction

  // ISA-level operation required of the ALU for an instruction.
  function automatic logic [3:0] alu_model(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7);
    if (o == OP_BR)  return 4'd1;
    if (o == OP_LUI) return 4'd2;
    if (o != OP_R && o != OP_I) return 4'd0;
    case (f3)
      3'd0:    return (o == OP_R && f7 == 7'b0100000) ? 4'd1 : 4'd0;
      3'd1:    return 4'd8;
      3'd2:    return 4'd6;
      3'd3:    return 4'd7;
      3'd4:    return 4'd5;
      3'd5:    return f7[5] ? 4'd10 : 4'd9;
      3'd6:    return 4'd4;
      default: return 4'd3;
    endcase
  endfunction

  // Branch outcome from the operand values themselves.
  function automatic logic taken_model(input logic [2:0] f3, input logic [31:0] a, b);
    case (f3)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return $signed(a) <  $signed(b);
      3'd5:    return $signed(a) >= $signed(b);
      3'd6:    return a <  b;
      3'd7:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic run_q(input int stop_at);
    int n;
    n = (stop_at < 0 || stop_at > q.size()) ? q.size() : stop_at;
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e = q[i];
      @(negedge clk);
      rst = 1'b0;
      mem_ready = e.rdy;
      if (i == 0) begin
        op = cur_op; funct3 = cur_f3; funct7 = cur_f7;
        Zero = cur_zero; Lt = cur_lt; Ltu = cur_ltu;
      end
      #1;
      chk("state", state, e.st);
      chk("MemReq", MemReq, e.memreq);
      chk("IRWrite", IRWrite, e.irw);
      chk("PCWrite", PCWrite, e.pcw);
      chk("PCSrc", PCSrc, e.pcsrc);
      chk("MemWrite", MemWrite, e.memw);
      chk("RegWrite", RegWrite, e.regw);
      chk("RegWSrc", RegWSrc, e.wsrc);
      chk("trap_idle", trap, 1'b0);
      chk("instret", instret, exp_instret);
      if (e.st == 3'd2) begin
        chk("ALUControl", ALUControl, exp_alu);
        chk("ImmSrc", ImmSrc, exp_imm);
        chk("ALUSrc", ALUSrc, exp_alusrc);
        chk("MemSrc", MemSrc, cur_f3);
      end
      if (e.pcw) exp_instret = exp_instret + 1'b1;
    end
  endtask

  task automatic check_trap(input int n, input logic [1:0] cause);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst = 1'b0;
      mem_ready = 1'($urandom_range(0, 1));
      #1;
      chk("trap_state", state, 3'd7);
      chk("trap_flag", trap, 1'b1);
      chk("trap_cause", trap_cause, cause);
      chk("trap_strobes", {MemReq, IRWrite, PCWrite, MemWrite, RegWrite}, 5'b0);
      chk("trap_instret", instret, exp_instret);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    mem_ready = 1'($urandom_range(0, 1));
    #1;
    chk("rst_strobes", {MemReq, IRWrite, PCWrite, MemWrite, RegWrite}, 5'b0);
    @(posedge clk);
    #1;
    exp_instret = '0;
    chk("rst_state", state, 3'd0);
    chk("rst_trap", trap, 1'b0);
    chk("rst_cause", trap_cause, 2'd0);
    chk("rst_instret", instret, '0);
  endtask

  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                           input logic [31:0] a, b, input int fw, mw, stop_at);
    logic br, ld, st, jal, jalr, tk;
    br = (o == OP_BR); ld = (o == OP_LOAD); st = (o == OP_STORE);
    jal = (o == OP_JAL); jalr = (o == OP_JALR);
    tk = taken_model(f3, a, b);
    cur_op = o; cur_f3 = f3; cur_f7 = f7;
    cur_zero = (a - b) == 32'd0;
    cur_lt = $signed(a) < $signed(b);
    cur_ltu = a < b;
    exp_alu = alu_model(o, f3, f7);
    exp_imm = br ? 3'd1 : st ? 3'd2 : jal ? 3'd3 : (o == OP_LUI) ? 3'd4 : 3'd0;
    exp_alusrc = !(br || o == OP_R);
    q.delete();
    for (int w = 0; w < fw; w++) q.push_back(mk(3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0));
    q.push_back(mk(3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0));
    q.push_back(mk(3'd1, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0));
    if (!is_legal(o)) begin
      run_q(-1);
      check_trap(20, 2'd1);
      return;
    end
    q.push_back(mk(3'd2, 1'($urandom_range(0, 1)), 1'b0, 1'b0, br, 1'b0, 1'b0,
                   (br && tk) ? 2'd1 : 2'd0, 2'd0));
    if (ld || st) begin
      for (int w = 0; w < mw; w++) q.push_back(mk(3'd3, 1'b0, 1'b1, 1'b0, 1'b0, st, 1'b0, 2'd0, 2'd0));
      q.push_back(mk(3'd3, 1'b1, 1'b1, 1'b0, st, st, 1'b0, 2'd0, 2'd0));
    end
    if (!br && !st)
      q.push_back(mk(3'd4, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b1, 1'b0, 1'b1,
                     jal ? 2'd1 : jalr ? 2'd2 : 2'd0,
                     ld ? 2'd1 : (jal || jalr) ? 2'd2 : 2'd0));
    run_q(stop_at);
  endtask

  task automatic rand_instr();
    logic [6:0] o, f7;
    logic [2:0] f3;
    o  = legal_ops[$urandom_range(0, 7)];
    f3 = (o == OP_BR) ? br_f3[$urandom_range(0, 5)] : 3'($urandom);
    case ($urandom_range(0, 2))
      0:       f7 = 7'b0000000;
      1:       f7 = 7'b0100000;
      default: f7 = 7'($urandom);
    endcase
    run_instr(o, f3, f7, vals[$urandom_range(0, 4)], vals[$urandom_range(0, 4)],
              $urandom_range(0, TO - 1), $urandom_range(0, TO - 1), -1);
  endtask

  task automatic rand_illegal();
    logic [6:0] o;
    do o = 7'($urandom); while (is_legal(o));
    run_instr(o, 3'($urandom), 7'($urandom), 32'd0, 32'd0, $urandom_range(0, TO - 1), 0, -1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    do_reset();

    run_instr(OP_R,     3'b000, 7'b0000000, 32'd5, 32'd3, 0, 0, -1);  // ADD
    run_instr(OP_LOAD,  3'b100, 7'b0000000, 32'd0, 32'd0, 0, 3, -1);  // LBU, 3 data waits
    run_instr(OP_BR,    3'b001, 7'b0000000, 32'd7, 32'd3, 0, 0, -1);  // BNE taken
    run_instr(OP_BR,    3'b111, 7'b0000000, 32'd1, 32'd2, 0, 0, -1);  // BGEU not taken
    run_instr(OP_R,     3'b000, 7'b0100000, 32'd1, 32'd2, 1, 0, -1);  // SUB
    run_instr(OP_I,     3'b000, 7'b0100000, 32'd1, 32'd2, 0, 0, -1);  // ADDI never sub
    run_instr(OP_I,     3'b101, 7'b0100000, 32'd1, 32'd2, 0, 0, -1);  // SRAI
    run_instr(OP_JAL,   3'b000, 7'b0000000, 32'd0, 32'd0, TO - 1, 0, -1);
    run_instr(OP_JALR,  3'b000, 7'b0000000, 32'd0, 32'd0, 2, 0, -1);
    run_instr(OP_LUI,   3'b000, 7'b0000000, 32'd0, 32'd0, 0, 0, -1);
    run_instr(OP_STORE, 3'b010, 7'b0000000, 32'd0, 32'd0, 0, TO - 1, -1);
    run_instr(7'b0000000, 3'b000, 7'b0000000, 32'd0, 32'd0, 0, 0, -1);  // illegal
    do_reset();

    for (int k = 0; k < 9; k++) rand_instr();
    @(negedge clk);
    rst = 1'b0;
    mem_ready = 1'b0;
    #1;
    chk("instret_wrap", instret, 3'd1);
    do_reset();

    for (int k = 0; k < 150; k++) begin
      if ($urandom_range(0, 14) == 0) begin
        rand_illegal();
        do_reset();
      end else begin
        rand_instr();
      end
    end

    do_reset();
    cur_op = OP_R; cur_f3 = '0; cur_f7 = '0;
    cur_zero = 1'b0; cur_lt = 1'b0; cur_ltu = 1'b0;
    q.delete();
    for (int w = 0; w < TO; w++) q.push_back(mk(3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0));
    run_q(-1);
    check_trap(20, 2'd2);
    do_reset();

    for (int k = 0; k < 3; k++) rand_instr();
    run_instr(OP_STORE, 3'b001, 7'b0000000, 32'd0, 32'd0, 0, TO - 1, 4);  // stop inside MEMORY wait
    do_reset();
    run_instr(OP_R, 3'b110, 7'b0000000, 32'd3, 32'd3, 0, 0, -1);
    run_instr(OP_BR, 3'b000, 7'b0000000, 32'd3, 32'd3, 0, 0, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
